// File: rtl/fetch_if_id_stage.sv
// Instruction fetch with one outstanding imem request, a 1-entry skid
// buffer and the IF/ID register feeding the decode-stage controller.
module fetch_if_id_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall_d,
   input  logic        redirect_e,
   input  logic [31:0] pc_target_e,
   output logic        valid_d,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d,
   output logic [6:0]  op_d,
   output logic [2:0]  funct3_d,
   output logic        funct7b5_d,
   output logic [4:0]  rs1_d,
   output logic [4:0]  rs2_d,
   output logic [4:0]  rd_d
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t      state_q, state_n;
   logic [31:0] pc_f_q, pc_f_n;
   logic [31:0] rsp_pc_q, rsp_pc_n;
   logic        drop_q, drop_n;
   logic        skid_v_q, skid_v_n;
   logic [31:0] skid_instr_q, skid_instr_n;
   logic [31:0] skid_pc_q, skid_pc_n;
   logic        valid_q, valid_n;
   logic [31:0] instr_q, instr_n;
   logic [31:0] pc_d_q, pc_d_n;

   logic        accept;
   logic        rsp;
   logic        rsp_use;
   logic        outstanding;
   logic        unused_tgt;

   // low target bits are forced to zero, so they are never looked at
   assign unused_tgt = ^pc_target_e[1:0];

   assign imem_req    = (state_q == REQ) && !skid_v_q;
   assign imem_addr   = pc_f_q;
   assign accept      = imem_req && imem_ready;
   assign rsp         = (state_q == WAIT) && imem_rvalid;
   assign rsp_use     = rsp && !drop_q && !redirect_e;
   assign outstanding = accept || ((state_q == WAIT) && !imem_rvalid);

   // fetch FSM next state; a redirect never changes the request protocol
   always_comb begin
      state_n = state_q;
      unique case (state_q)
         IDLE: state_n = REQ;
         REQ: begin
            if (accept) begin
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_n = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // fetch PC, PC of the in-flight request and the drop flag
   always_comb begin
      pc_f_n   = pc_f_q;
      rsp_pc_n = rsp_pc_q;
      drop_n   = drop_q;
      if (accept) begin
         rsp_pc_n = pc_f_q;
      end
      if (rsp) begin
         drop_n = 1'b0;
      end
      if (redirect_e) begin
         pc_f_n = {pc_target_e[31:2], 2'b00};
         if (outstanding) begin
            drop_n = 1'b1;
         end
      end else if (accept) begin
         pc_f_n = pc_f_q + 32'd4;
      end
   end

   // IF/ID register and skid buffer: flush > stall > skid > response > bubble
   always_comb begin
      valid_n      = valid_q;
      instr_n      = instr_q;
      pc_d_n       = pc_d_q;
      skid_v_n     = skid_v_q;
      skid_instr_n = skid_instr_q;
      skid_pc_n    = skid_pc_q;
      if (redirect_e) begin
         valid_n  = 1'b0;
         instr_n  = NOP_INSTR;
         skid_v_n = 1'b0;
      end else if (stall_d) begin
         if (rsp_use) begin
            skid_v_n     = 1'b1;
            skid_instr_n = imem_rdata;
            skid_pc_n    = rsp_pc_q;
         end
      end else if (skid_v_q) begin
         valid_n  = 1'b1;
         instr_n  = skid_instr_q;
         pc_d_n   = skid_pc_q;
         skid_v_n = 1'b0;
      end else if (rsp_use) begin
         valid_n = 1'b1;
         instr_n = imem_rdata;
         pc_d_n  = rsp_pc_q;
      end else begin
         valid_n = 1'b0;
         instr_n = NOP_INSTR;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         pc_f_q       <= RESET_PC;
         rsp_pc_q     <= RESET_PC;
         drop_q       <= 1'b0;
         skid_v_q     <= 1'b0;
         skid_instr_q <= NOP_INSTR;
         skid_pc_q    <= 32'd0;
         valid_q      <= 1'b0;
         instr_q      <= NOP_INSTR;
         pc_d_q       <= 32'd0;
      end else begin
         state_q      <= state_n;
         pc_f_q       <= pc_f_n;
         rsp_pc_q     <= rsp_pc_n;
         drop_q       <= drop_n;
         skid_v_q     <= skid_v_n;
         skid_instr_q <= skid_instr_n;
         skid_pc_q    <= skid_pc_n;
         valid_q      <= valid_n;
         instr_q      <= instr_n;
         pc_d_q       <= pc_d_n;
      end
   end

   assign valid_d    = valid_q;
   assign instr_d    = instr_q;
   assign pc_d       = pc_d_q;
   assign pc_plus4_d = pc_d_q + 32'd4;
   assign op_d       = instr_q[6:0];
   assign funct3_d   = instr_q[14:12];
   assign funct7b5_d = instr_q[30];
   assign rs1_d      = instr_q[19:15];
   assign rs2_d      = instr_q[24:20];
   assign rd_d       = instr_q[11:7];

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Bench for fetch_if_id_stage: directed vector table, reset-in-flight
// sequence and randomized traffic against a transactional model.
module tb_fetch_if_id_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata;
   logic        stall_d = 1'b0;
   logic        redirect_e = 1'b0;
   logic [31:0] pc_target_e = 32'd0;
   logic        valid_d;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;
   logic [6:0]  op_d;
   logic [2:0]  funct3_d;
   logic        funct7b5_d;
   logic [4:0]  rs1_d;
   logic [4:0]  rs2_d;
   logic [4:0]  rd_d;

   int checks = 0;
   int errors = 0;

   fetch_if_id_stage dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata),
      .stall_d(stall_d), .redirect_e(redirect_e),
      .pc_target_e(pc_target_e),
      .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
      .pc_plus4_d(pc_plus4_d), .op_d(op_d), .funct3_d(funct3_d),
      .funct7b5_d(funct7b5_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
      .rd_d(rd_d)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'h0019_3A5B) ^ 32'hC0DE_0033;
   endfunction

   // instruction memory: returns the word of the last accepted address
   logic [31:0] lat_addr = 32'd0;
   always @(posedge clk) begin
      if (imem_req && imem_ready) lat_addr <= imem_addr;
   end
   assign imem_rdata = word(lat_addr);

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic e_req,
                            input logic [31:0] e_addr,
                            input logic e_valid,
                            input logic [31:0] e_pc,
                            input logic [31:0] e_instr);
      logic [31:0] ei;
      ei = e_instr;
      chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, e_req});
      chk({tag, ".addr"}, imem_addr, e_addr);
      chk({tag, ".valid"}, {31'd0, valid_d}, {31'd0, e_valid});
      chk({tag, ".pc_d"}, pc_d, e_pc);
      chk({tag, ".pc4"}, pc_plus4_d, e_pc + 32'd4);
      chk({tag, ".instr"}, instr_d, ei);
      chk({tag, ".fields"},
          {6'd0, op_d, funct3_d, funct7b5_d, rs1_d, rs2_d, rd_d},
          {6'd0, ei[6:0], ei[14:12], ei[30], ei[19:15], ei[24:20],
           ei[11:7]});
   endtask

   typedef struct {
      logic        ready;
      logic        rvalid;
      logic        stall;
      logic        redir;
      logic [31:0] tgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   function automatic vec_t mk(input logic rdy, rv, st, rd,
                               input logic [31:0] tg,
                               input logic er,
                               input logic [31:0] ea,
                               input logic ev,
                               input logic [31:0] ep);
      vec_t v;
      v.ready = rdy; v.rvalid = rv; v.stall = st; v.redir = rd;
      v.tgt = tg; v.e_req = er; v.e_addr = ea;
      v.e_valid = ev; v.e_pc = ep;
      return v;
   endfunction

   vec_t tbl[35];

   // transactional reference model
   bit          m_started;
   logic [31:0] m_pc;
   bit          m_outst;
   logic [31:0] m_opc;
   bit          m_drop;
   bit          m_skid_v;
   logic [31:0] m_sw, m_sp;
   bit          m_v;
   logic [31:0] m_i, m_p;

   task automatic m_reset();
      m_started = 0; m_pc = 32'd0; m_outst = 0; m_opc = 32'd0;
      m_drop = 0; m_skid_v = 0; m_sw = 32'd0; m_sp = 32'd0;
      m_v = 0; m_i = NOP; m_p = 32'd0;
   endtask

   task automatic m_step(input bit rdy, rv, st, rd,
                         input logic [31:0] tg);
      bit acc, rsp, keep;
      logic [31:0] old_opc;
      if (!m_started) begin
         m_started = 1;
         return;
      end
      acc = !m_outst && !m_skid_v && rdy;
      rsp = m_outst && rv;
      keep = rsp && !m_drop && !rd;
      old_opc = m_opc;
      if (rsp) begin
         m_outst = 0;
         m_drop = 0;
      end
      if (acc) begin
         m_outst = 1;
         m_opc = m_pc;
         m_drop = rd;
      end
      if (rd && m_outst) m_drop = 1;
      if (rd) m_pc = {tg[31:2], 2'b00};
      else if (acc) m_pc = m_pc + 32'd4;
      if (rd) begin
         m_skid_v = 0; m_v = 0; m_i = NOP;
      end else if (st) begin
         if (keep) begin
            m_skid_v = 1; m_sw = word(old_opc); m_sp = old_opc;
         end
      end else if (m_skid_v) begin
         m_v = 1; m_i = m_sw; m_p = m_sp; m_skid_v = 0;
      end else if (keep) begin
         m_v = 1; m_i = word(old_opc); m_p = old_opc;
      end else begin
         m_v = 0; m_i = NOP;
      end
   endtask

   initial begin
      // startup, ready=1, zero-wait memory
      tbl[0]  = mk(1,0,0,0,0,           1,32'h0,  0,32'h0);
      tbl[1]  = mk(1,0,0,0,0,           0,32'h4,  0,32'h0);
      tbl[2]  = mk(0,1,0,0,0,           1,32'h4,  1,32'h0);
      tbl[3]  = mk(1,0,0,0,0,           0,32'h8,  0,32'h0);
      tbl[4]  = mk(0,1,0,0,0,           1,32'h8,  1,32'h4);
      tbl[5]  = mk(1,0,0,0,0,           0,32'hC,  0,32'h4);
      tbl[6]  = mk(0,1,0,0,0,           1,32'hC,  1,32'h8);
      tbl[7]  = mk(1,0,0,0,0,           0,32'h10, 0,32'h8);
      tbl[8]  = mk(0,1,0,0,0,           1,32'h10, 1,32'hC);
      // stall while the next word returns: skid holds it
      tbl[9]  = mk(1,0,1,0,0,           0,32'h14, 1,32'hC);
      tbl[10] = mk(0,1,1,0,0,           0,32'h14, 1,32'hC);
      tbl[11] = mk(1,0,1,0,0,           0,32'h14, 1,32'hC);
      tbl[12] = mk(1,0,1,0,0,           0,32'h14, 1,32'hC);
      tbl[13] = mk(0,0,0,0,0,           1,32'h14, 1,32'h10);
      tbl[14] = mk(1,0,0,0,0,           0,32'h18, 0,32'h10);
      // redirect while waiting, late response dropped
      tbl[15] = mk(0,0,0,1,32'h103,     0,32'h100,0,32'h10);
      tbl[16] = mk(0,1,0,0,0,           1,32'h100,0,32'h10);
      tbl[17] = mk(1,0,0,0,0,           0,32'h104,0,32'h10);
      tbl[18] = mk(0,1,0,0,0,           1,32'h104,1,32'h100);
      // redirect with stall and full skid
      tbl[19] = mk(1,0,1,0,0,           0,32'h108,1,32'h100);
      tbl[20] = mk(0,1,1,0,0,           0,32'h108,1,32'h100);
      tbl[21] = mk(1,0,1,1,32'h200,     1,32'h200,0,32'h100);
      tbl[22] = mk(1,0,0,0,0,           0,32'h204,0,32'h100);
      tbl[23] = mk(0,1,0,0,0,           1,32'h204,1,32'h200);
      // ready low: request held
      tbl[24] = mk(0,0,0,0,0,           1,32'h204,0,32'h200);
      tbl[25] = mk(0,0,0,0,0,           1,32'h204,0,32'h200);
      tbl[26] = mk(0,0,0,0,0,           1,32'h204,0,32'h200);
      // PC wrap at 2^32
      tbl[27] = mk(0,0,0,1,32'hFFFF_FFFC,1,32'hFFFF_FFFC,0,32'h200);
      tbl[28] = mk(1,0,0,0,0,           0,32'h0,  0,32'h200);
      tbl[29] = mk(0,1,0,0,0,           1,32'h0,  1,32'hFFFF_FFFC);
      // redirect together with rvalid: no drop left behind
      tbl[30] = mk(1,0,0,0,0,           0,32'h4,  0,32'hFFFF_FFFC);
      tbl[31] = mk(0,1,0,1,32'h300,     1,32'h300,0,32'hFFFF_FFFC);
      tbl[32] = mk(1,0,0,0,0,           0,32'h304,0,32'hFFFF_FFFC);
      tbl[33] = mk(0,1,0,0,0,           1,32'h304,1,32'h300);
      tbl[34] = mk(1,0,0,0,0,           0,32'h308,0,32'h300);

      @(negedge clk);
      @(negedge clk);
      check_out("rst", 0, 32'h0, 0, 32'h0, NOP);
      reset_n = 1'b1;
      for (int i = 0; i < 35; i++) begin
         imem_ready  = tbl[i].ready;
         imem_rvalid = tbl[i].rvalid;
         stall_d     = tbl[i].stall;
         redirect_e  = tbl[i].redir;
         pc_target_e = tbl[i].tgt;
         @(negedge clk);
         check_out($sformatf("vec%0d", i), tbl[i].e_req,
                   tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc,
                   tbl[i].e_valid ? word(tbl[i].e_pc) : NOP);
      end

      // async reset while a request is outstanding
      imem_ready = 1'b0; imem_rvalid = 1'b0;
      stall_d = 1'b0; redirect_e = 1'b0;
      #2 reset_n = 1'b0;
      #1 check_out("arst", 0, 32'h0, 0, 32'h0, NOP);
      imem_rvalid = 1'b1;
      @(negedge clk);
      check_out("arst_hold", 0, 32'h0, 0, 32'h0, NOP);
      reset_n = 1'b1;
      @(negedge clk);
      check_out("late_rv0", 1, 32'h0, 0, 32'h0, NOP);
      @(negedge clk);
      check_out("late_rv1", 1, 32'h0, 0, 32'h0, NOP);
      imem_ready = 1'b1; imem_rvalid = 1'b0;
      @(negedge clk);
      check_out("restart0", 0, 32'h4, 0, 32'h0, NOP);
      imem_ready = 1'b0; imem_rvalid = 1'b1;
      @(negedge clk);
      check_out("restart1", 1, 32'h4, 1, 32'h0, word(32'h0));

      // randomized traffic against the model
      imem_rvalid = 1'b0; imem_ready = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      m_reset();
      for (int c = 0; c < 3000; c++) begin
         bit rdy, rv, st, rd;
         logic [31:0] tg;
         check_out("rnd", m_started && !m_outst && !m_skid_v, m_pc,
                   m_v, m_p, m_i);
         if (errors > 20) break;
         rdy = ($urandom % 4) != 0;
         st  = ($urandom % 4) == 0;
         rd  = m_started && (($urandom % 12) == 0);
         rv  = m_outst ? (($urandom % 3) != 0) : (($urandom % 8) == 0);
         tg  = $urandom;
         if (($urandom % 4) == 0) tg = 32'hFFFF_FFF0 | (tg & 32'hF);
         imem_ready = rdy; imem_rvalid = rv; stall_d = st;
         redirect_e = rd; pc_target_e = tg;
         m_step(rdy, rv, st, rd, tg);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
